dllp_rx_vc_handler: RTL and testbench
=====================================

Name: dllp_rx_vc_handler

Overview:
Receive-side DLLP decoder that generalises the single-VC DLLP handler. It accepts 6-byte DLLPs (4-byte body plus 16-bit CRC) from the PHY AXIS stream at 32- or 64-bit width and checks the CRC. It emits Ack/Nak sequence pulses to the replay logic and maintains InitFC1/InitFC2/UpdateFC credits for P, NP and Cpl on NUM_VC virtual channels. Unlike the previous block, bad CRC and framing errors are dropped and counted rather than stalling the FSM.

Parameters:
DATA_WIDTH, 32, AXIS data width; only 32 (two beats per DLLP) or 64 (one beat) are legal; assert otherwise.
KEEP_WIDTH, DATA_WIDTH/8, tkeep width; tkeep is ignored.
USER_WIDTH, 3, tuser width; tuser is ignored.
NUM_VC, 1, number of supported VCs, 1..8.
ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
link_status_i  in  2  DL_INACTIVE / DL_INIT / DL_ACTIVE (pcie_datalink_pkg)
s_axis_tdata_i  in  DATA_WIDTH  DLLP bytes, byte0 in [7:0]
s_axis_tkeep_i  in  KEEP_WIDTH  unused
s_axis_tvalid_i  in  1  beat valid
s_axis_tlast_i  in  1  last beat of DLLP
s_axis_tuser_i  in  USER_WIDTH  unused
s_axis_tready_o  out  1  beat accepted
seq_num_o  out  12  Ack/Nak sequence number
seq_num_vld_o  out  1  one-cycle pulse
seq_num_acknack_o  out  1  1 = Ack, 0 = Nak; qualified by vld
fc1_values_stored_o  out  NUM_VC  per VC: InitFC1 P, NP and Cpl all received
fc2_values_stored_o  out  NUM_VC  per VC: InitFC2 P, NP and Cpl all received
tx_fc_ph_o, tx_fc_nph_o, tx_fc_cplh_o  out  8*NUM_VC  header credits, VC v at [8v+7:8v]
tx_fc_pd_o, tx_fc_npd_o, tx_fc_cpld_o  out  12*NUM_VC  data credits, VC v at [12v+11:12v]
dllp_err_cnt_o  out  ERR_CNT_WIDTH  saturating count of CRC and framing errors

Behaviour:
- Reset: FSM in ST_IDLE; all outputs 0 except s_axis_tready_o, which is combinational and 0 while not in an accepting state.
- Field decode:
  - type = byte0; HdrFC = {byte1[5:0], byte2[7:6]}; DataFC = {byte2[3:0], byte3}; AckNak seq = {byte2[3:0], byte3}.
  - FC types: type[7:4] = 0100/0101/0110 InitFC1 P/NP/Cpl; 1100/1101/1110 InitFC2 P/NP/Cpl; 1000/1001/1010 UpdateFC P/NP/Cpl.
  - FC types require type[3] = 0; VC = type[2:0]. Ack = 0x00, Nak = 0x10.
- The received CRC field is byte4/byte5. For DATA_WIDTH=32 it is tdata[15:0] of beat 2; for 64 it is tdata[47:32].
- FSM states:
  - ST_IDLE: tready = 1 when link is DL_INIT or DL_ACTIVE. On a valid beat, register the body and CRC-module result.
    - DW=64: if tlast = 1, go to ST_CHECK; otherwise it is a framing error, go to ST_DRAIN.
    - DW=32: if tlast = 1 it is a framing error, stay in ST_IDLE; otherwise go to ST_CRC.
  - ST_CRC (DW=32 only): tready = 1. On a valid beat, compare CRC and go to ST_CHECK; if tlast = 0 it is a framing error, go to ST_DRAIN.
  - ST_DRAIN: tready = 1; discard beats until tlast, then go to ST_IDLE.
  - ST_CHECK: tready = 0. On CRC mismatch, count an error and go to ST_IDLE. Otherwise decode, update registers and go to ST_IDLE.
- Registered outputs become visible the cycle after ST_CHECK. Latency from last beat to seq_num_vld_o is 2 clocks.
- Ack/Nak: pulse only when link = DL_ACTIVE; dropped silently in DL_INIT.
- InitFC1_x / InitFC2_x:
  - Load credits for (VC, type) and set the matching stored bit.
  - Ignored if that stored bit is already set, so the first value wins.
- UpdateFC_x: overwrites credits for (VC, type) unconditionally.
- Any DLLP whose VC >= NUM_VC is ignored, with no error counted. Unknown types (PM, vendor) are ignored.
- Error counter: +1 per CRC or framing error; saturates at all-ones.
- link_status_i = DL_INACTIVE: synchronous clear of credits and stored flags; FSM forced to ST_IDLE, which aborts a DLLP mid-receive. The error counter is preserved.
- A link drop to DL_INACTIVE during ST_CHECK suppresses that DLLP's update.

Decomposition:
- pcie_datalink_pkg gains:
  - link-state enum values (reuse existing);
  - DLLP type-nibble constants;
  - fc_type_e {FC_P, FC_NP, FC_CPL};
  - field-extract functions get_fc_hdr, get_fc_data, get_fc_vc, get_ack_nack_seq.
- CRC: instantiate the existing pcie_datalink_crc (crcIn all-ones, 32-bit data = body), fed from tdata[31:0] of the first beat.
- Per-VC credit/flag storage: a generate loop in this module; no further sub-module.

Test Plan:
- DW=32, DL_ACTIVE: Ack seq 0x123 with good CRC -> seq_num_vld_o pulses 2 clocks after the CRC beat; seq_num_o = 0x123, acknack = 1.
- DW=64, NUM_VC=2, DL_INIT: InitFC1 P/NP/Cpl for VC1 (HdrFC 0x20, DataFC 0x400) -> fc1_values_stored_o = 2'b10; tx_fc_ph_o[15:8] = 0x20; tx_fc_pd_o[23:12] = 0x400. A second InitFC1_P with HdrFC 0x10 leaves the value at 0x20.
- Nak seq 0x7FF with CRC bit flipped -> no seq pulse; dllp_err_cnt_o increments to 1. A following good Nak is accepted with acknack = 0.
- DW=32: tlast on the first beat, then a 3-beat burst -> two framing errors counted (err_cnt = 2); FSM returns to ST_IDLE; the next good DLLP is decoded.
- UpdateFC_NP for VC5 with NUM_VC=2 -> no credit change, no error. UpdateFC_NP for VC0 (0x08, 0x0FF) -> tx_fc_nph_o[7:0] = 0x08, tx_fc_npd_o[11:0] = 0x0FF.
- Link drops to DL_INACTIVE between beats of a DW=32 DLLP -> credits and flags clear; no decode occurs. Error counter is preserved and the next DLLP is received normally.

Source files
------------

// File: rtl/pcie_datalink_pkg.sv
// Shared data-link-layer definitions: link states, DLLP type codes,
// flow-control type enum, receive FSM states and DLLP body field extractors.
// A DLLP body is 4 bytes packed little-endian (byte0 in [7:0]).
package pcie_datalink_pkg;

  typedef enum logic [1:0] {
    DL_INACTIVE = 2'd0,
    DL_INIT     = 2'd1,
    DL_ACTIVE   = 2'd2
  } link_status_e;

  // Upper type nibble of flow-control DLLPs
  localparam logic [3:0] DLLP_INITFC1_P   = 4'h4;
  localparam logic [3:0] DLLP_INITFC1_NP  = 4'h5;
  localparam logic [3:0] DLLP_INITFC1_CPL = 4'h6;
  localparam logic [3:0] DLLP_INITFC2_P   = 4'hC;
  localparam logic [3:0] DLLP_INITFC2_NP  = 4'hD;
  localparam logic [3:0] DLLP_INITFC2_CPL = 4'hE;
  localparam logic [3:0] DLLP_UPDFC_P     = 4'h8;
  localparam logic [3:0] DLLP_UPDFC_NP    = 4'h9;
  localparam logic [3:0] DLLP_UPDFC_CPL   = 4'hA;

  localparam logic [7:0] DLLP_ACK = 8'h00;
  localparam logic [7:0] DLLP_NAK = 8'h10;

  typedef enum logic [1:0] {FC_P = 2'd0, FC_NP = 2'd1, FC_CPL = 2'd2} fc_type_e;

  typedef enum logic [1:0] {ST_IDLE, ST_CRC, ST_DRAIN, ST_CHECK} dllp_rx_state_e;

  function automatic logic [7:0] get_fc_hdr(input logic [31:0] body);
    return {body[13:8], body[23:22]};
  endfunction

  function automatic logic [11:0] get_fc_data(input logic [31:0] body);
    return {body[19:16], body[31:24]};
  endfunction

  function automatic logic [2:0] get_fc_vc(input logic [31:0] body);
    return body[2:0];
  endfunction

  function automatic logic [11:0] get_ack_nack_seq(input logic [31:0] body);
    return {body[19:16], body[31:24]};
  endfunction

endpackage

// File: rtl/pcie_datalink_crc.sv
// DLLP CRC-16 (poly 0x100B) over a 32-bit body, bytes in order, LSB first.
// Ports: crc_in_i seed, data_i body (byte0 in [7:0]), crc_o inverted result
// whose high byte travels as DLLP byte4 and low byte as byte5.
module pcie_datalink_crc (
  input  logic [15:0] crc_in_i,
  input  logic [31:0] data_i,
  output logic [15:0] crc_o
);

  logic [15:0] c;
  logic        fb;

  always_comb begin
    c  = crc_in_i;
    fb = 1'b0;
    for (int b = 0; b < 32; b++) begin
      fb = c[15] ^ data_i[b];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
    end
    crc_o = ~c;
  end

endmodule

// File: rtl/dllp_rx_vc_handler.sv
// Receive DLLP decoder: takes 6-byte DLLPs from the PHY AXIS stream (one
// 64-bit beat or two 32-bit beats), checks CRC, pulses Ack/Nak sequence
// numbers and keeps InitFC1/InitFC2/UpdateFC credits per VC.
// Ports: clk_i/rst_i; link_status_i; s_axis_* input stream (tkeep/tuser
// ignored); seq_num_* Ack/Nak pulse; fc1/fc2_values_stored_o per-VC flags;
// tx_fc_* credits (VC v at [8v+7:8v] / [12v+11:12v]); dllp_err_cnt_o
// saturating CRC/framing error count (survives link down).
module dllp_rx_vc_handler
  import pcie_datalink_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int KEEP_WIDTH    = DATA_WIDTH/8,
  parameter int USER_WIDTH    = 3,
  parameter int NUM_VC        = 1,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               link_status_i,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata_i,
  input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep_i,
  input  logic                     s_axis_tvalid_i,
  input  logic                     s_axis_tlast_i,
  input  logic [USER_WIDTH-1:0]    s_axis_tuser_i,
  output logic                     s_axis_tready_o,
  output logic [11:0]              seq_num_o,
  output logic                     seq_num_vld_o,
  output logic                     seq_num_acknack_o,
  output logic [NUM_VC-1:0]        fc1_values_stored_o,
  output logic [NUM_VC-1:0]        fc2_values_stored_o,
  output logic [8*NUM_VC-1:0]      tx_fc_ph_o,
  output logic [8*NUM_VC-1:0]      tx_fc_nph_o,
  output logic [8*NUM_VC-1:0]      tx_fc_cplh_o,
  output logic [12*NUM_VC-1:0]     tx_fc_pd_o,
  output logic [12*NUM_VC-1:0]     tx_fc_npd_o,
  output logic [12*NUM_VC-1:0]     tx_fc_cpld_o,
  output logic [ERR_CNT_WIDTH-1:0] dllp_err_cnt_o
);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_dw
    $error("dllp_rx_vc_handler: DATA_WIDTH must be 32 or 64");
  end
  if (NUM_VC < 1 || NUM_VC > 8) begin : g_bad_vc
    $error("dllp_rx_vc_handler: NUM_VC must be 1..8");
  end

  dllp_rx_state_e state_q, state_d;
  logic [31:0] body_q;
  logic [15:0] crc_calc, crc_calc_q, crc_rx_q, crc_field;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
  logic link_up, link_down, beat, frm_err, check_vld, dllp_ok, crc_err;

  assign link_down = (link_status_i == DL_INACTIVE);
  assign link_up   = (link_status_i == DL_INIT) || (link_status_i == DL_ACTIVE);
  assign beat      = s_axis_tvalid_i && s_axis_tready_o;

  pcie_datalink_crc u_crc (
    .crc_in_i (16'hFFFF),
    .data_i   (s_axis_tdata_i[31:0]),
    .crc_o    (crc_calc)
  );

  // Received CRC as {byte4, byte5}, from whichever beat carries it
  if (DATA_WIDTH == 64) begin : g_crc64
    assign crc_field = {s_axis_tdata_i[39:32], s_axis_tdata_i[47:40]};
  end else begin : g_crc32
    assign crc_field = {s_axis_tdata_i[7:0], s_axis_tdata_i[15:8]};
  end

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;

  // FSM: next state and framing-error detect
  always_comb begin
    state_d = state_q;
    frm_err = 1'b0;
    unique case (state_q)
      ST_IDLE: if (beat) begin
        if (DATA_WIDTH == 64) begin
          if (s_axis_tlast_i) state_d = ST_CHECK;
          else begin state_d = ST_DRAIN; frm_err = 1'b1; end
        end else begin
          if (s_axis_tlast_i) frm_err = 1'b1;
          else                state_d = ST_CRC;
        end
      end
      ST_CRC: if (beat) begin
        if (s_axis_tlast_i) state_d = ST_CHECK;
        else begin state_d = ST_DRAIN; frm_err = 1'b1; end
      end
      ST_DRAIN: if (beat && s_axis_tlast_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Losing the link aborts whatever is in flight
    if (!link_up) begin
      state_d = ST_IDLE;
      frm_err = 1'b0;
    end
  end

  // FSM: outputs
  always_comb begin
    s_axis_tready_o = 1'b0;
    if (link_up && (state_q == ST_IDLE || state_q == ST_CRC || state_q == ST_DRAIN))
      s_axis_tready_o = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      body_q     <= '0;
      crc_calc_q <= '0;
      crc_rx_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && beat) begin
        body_q     <= s_axis_tdata_i[31:0];
        crc_calc_q <= crc_calc;
      end
      if ((state_q == ST_IDLE && beat && DATA_WIDTH == 64) || (state_q == ST_CRC && beat))
        crc_rx_q <= crc_field;
    end

  assign check_vld = (state_q == ST_CHECK) && link_up;
  assign dllp_ok   = check_vld && (crc_calc_q == crc_rx_q);
  assign crc_err   = check_vld && (crc_calc_q != crc_rx_q);

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)                                 err_cnt_q <= '0;
    else if ((frm_err || crc_err) && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);

  assign dllp_err_cnt_o = err_cnt_q;

  // Ack/Nak
  logic ack_hit, nak_hit;
  assign ack_hit = (body_q[7:0] == DLLP_ACK);
  assign nak_hit = (body_q[7:0] == DLLP_NAK);

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      seq_num_vld_o     <= 1'b0;
      seq_num_o         <= '0;
      seq_num_acknack_o <= 1'b0;
    end else begin
      seq_num_vld_o <= dllp_ok && (link_status_i == DL_ACTIVE) && (ack_hit || nak_hit);
      if (dllp_ok && (link_status_i == DL_ACTIVE) && (ack_hit || nak_hit)) begin
        seq_num_o         <= get_ack_nack_seq(body_q);
        seq_num_acknack_o <= ack_hit;
      end
    end

  // Flow-control decode
  logic       fc1_hit, fc2_hit, upd_hit, vc_ok, fc_sel;
  fc_type_e   fc_t;
  logic [2:0] fc_vc;
  logic [7:0] fc_hdr;
  logic [11:0] fc_data;

  assign fc_vc   = get_fc_vc(body_q);
  assign fc_hdr  = get_fc_hdr(body_q);
  assign fc_data = get_fc_data(body_q);
  assign vc_ok   = ({1'b0, fc_vc} < 4'(NUM_VC));
  assign fc_sel  = dllp_ok && vc_ok && (fc1_hit || fc2_hit || upd_hit);

  always_comb begin
    fc1_hit = 1'b0;
    fc2_hit = 1'b0;
    upd_hit = 1'b0;
    fc_t    = FC_P;
    if (!body_q[3]) begin
      case (body_q[7:4])
        DLLP_INITFC1_P:   begin fc1_hit = 1'b1; fc_t = FC_P;   end
        DLLP_INITFC1_NP:  begin fc1_hit = 1'b1; fc_t = FC_NP;  end
        DLLP_INITFC1_CPL: begin fc1_hit = 1'b1; fc_t = FC_CPL; end
        DLLP_INITFC2_P:   begin fc2_hit = 1'b1; fc_t = FC_P;   end
        DLLP_INITFC2_NP:  begin fc2_hit = 1'b1; fc_t = FC_NP;  end
        DLLP_INITFC2_CPL: begin fc2_hit = 1'b1; fc_t = FC_CPL; end
        DLLP_UPDFC_P:     begin upd_hit = 1'b1; fc_t = FC_P;   end
        DLLP_UPDFC_NP:    begin upd_hit = 1'b1; fc_t = FC_NP;  end
        DLLP_UPDFC_CPL:   begin upd_hit = 1'b1; fc_t = FC_CPL; end
        default: ;
      endcase
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [2:0]       fc1_q, fc2_q;
    logic [2:0][7:0]  hdr_q;
    logic [2:0][11:0] dat_q;
    logic hit, load;

    assign hit  = fc_sel && (fc_vc == 3'(v));
    // InitFC only loads the first time for each type; UpdateFC always does
    assign load = upd_hit || (fc1_hit && !fc1_q[fc_t]) || (fc2_hit && !fc2_q[fc_t]);

    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i || link_down) begin
        fc1_q <= '0;
        fc2_q <= '0;
        hdr_q <= '0;
        dat_q <= '0;
      end else if (hit) begin
        if (load) begin
          hdr_q[fc_t] <= fc_hdr;
          dat_q[fc_t] <= fc_data;
        end
        if (fc1_hit) fc1_q[fc_t] <= 1'b1;
        if (fc2_hit) fc2_q[fc_t] <= 1'b1;
      end

    assign fc1_values_stored_o[v]  = &fc1_q;
    assign fc2_values_stored_o[v]  = &fc2_q;
    assign tx_fc_ph_o[8*v +: 8]    = hdr_q[FC_P];
    assign tx_fc_nph_o[8*v +: 8]   = hdr_q[FC_NP];
    assign tx_fc_cplh_o[8*v +: 8]  = hdr_q[FC_CPL];
    assign tx_fc_pd_o[12*v +: 12]  = dat_q[FC_P];
    assign tx_fc_npd_o[12*v +: 12] = dat_q[FC_NP];
    assign tx_fc_cpld_o[12*v +: 12] = dat_q[FC_CPL];
  end

  logic unused_bits;
  assign unused_bits = ^{s_axis_tkeep_i, s_axis_tuser_i, s_axis_tdata_i, body_q};

endmodule

// File: tb/tb_dllp_rx_vc_handler.sv
// Bench: two handlers (32-bit/NUM_VC=2 and 64-bit/NUM_VC=2 with a 2-bit
// error counter) driven by directed DLLPs. A DLLP-level model predicts all
// outputs and is compared every cycle; literal checks pin key values.
module tb_dllp_rx_vc_handler;
  import pcie_datalink_pkg::*;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: 32-bit
  logic [1:0]  a_link = 2'd0;
  logic [31:0] a_tdata = '0;
  logic [3:0]  a_tkeep = '1;
  logic        a_tvalid = 1'b0, a_tlast = 1'b0;
  logic [2:0]  a_tuser = '0;
  logic        a_tready, a_vld, a_ack;
  logic [11:0] a_seq;
  logic [1:0]  a_fc1, a_fc2;
  logic [15:0] a_ph, a_nph, a_cplh, a_err;
  logic [23:0] a_pd, a_npd, a_cpld;

  // DUT B: 64-bit
  logic [1:0]  b_link = 2'd0;
  logic [63:0] b_tdata = '0;
  logic [7:0]  b_tkeep = '1;
  logic        b_tvalid = 1'b0, b_tlast = 1'b0;
  logic [2:0]  b_tuser = '0;
  logic        b_tready, b_vld, b_ack;
  logic [11:0] b_seq;
  logic [1:0]  b_fc1, b_fc2, b_err;
  logic [15:0] b_ph, b_nph, b_cplh;
  logic [23:0] b_pd, b_npd, b_cpld;

  dllp_rx_vc_handler #(.DATA_WIDTH(32), .NUM_VC(2), .ERR_CNT_WIDTH(16)) u_a (
    .clk_i(clk), .rst_i(rst), .link_status_i(a_link),
    .s_axis_tdata_i(a_tdata), .s_axis_tkeep_i(a_tkeep), .s_axis_tvalid_i(a_tvalid),
    .s_axis_tlast_i(a_tlast), .s_axis_tuser_i(a_tuser), .s_axis_tready_o(a_tready),
    .seq_num_o(a_seq), .seq_num_vld_o(a_vld), .seq_num_acknack_o(a_ack),
    .fc1_values_stored_o(a_fc1), .fc2_values_stored_o(a_fc2),
    .tx_fc_ph_o(a_ph), .tx_fc_nph_o(a_nph), .tx_fc_cplh_o(a_cplh),
    .tx_fc_pd_o(a_pd), .tx_fc_npd_o(a_npd), .tx_fc_cpld_o(a_cpld),
    .dllp_err_cnt_o(a_err));

  dllp_rx_vc_handler #(.DATA_WIDTH(64), .NUM_VC(2), .ERR_CNT_WIDTH(2)) u_b (
    .clk_i(clk), .rst_i(rst), .link_status_i(b_link),
    .s_axis_tdata_i(b_tdata), .s_axis_tkeep_i(b_tkeep), .s_axis_tvalid_i(b_tvalid),
    .s_axis_tlast_i(b_tlast), .s_axis_tuser_i(b_tuser), .s_axis_tready_o(b_tready),
    .seq_num_o(b_seq), .seq_num_vld_o(b_vld), .seq_num_acknack_o(b_ack),
    .fc1_values_stored_o(b_fc1), .fc2_values_stored_o(b_fc2),
    .tx_fc_ph_o(b_ph), .tx_fc_nph_o(b_nph), .tx_fc_cplh_o(b_cplh),
    .tx_fc_pd_o(b_pd), .tx_fc_npd_o(b_npd), .tx_fc_cpld_o(b_cpld),
    .dllp_err_cnt_o(b_err));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int m_hdr[2][2][3], m_dat[2][2][3];
  bit m_s1[2][2][3], m_s2[2][2][3];
  int m_err[2], m_seq[2];
  bit m_vld[2], m_ack[2];
  int err_max[2] = '{65535, 3};
  bit cap_vld, cap_ack;
  int cap_seq;

  function automatic logic [15:0] dllp_crc(input logic [7:0] b0, b1, b2, b3);
    logic [7:0] bb[4];
    logic [15:0] c;
    bit fb;
    bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
    c = 16'hFFFF;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ bb[k][i];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
      end
    return ~c;
  endfunction

  task automatic err_inc(input int d);
    if (m_err[d] < err_max[d]) m_err[d]++;
  endtask

  task automatic model_clear(input int d);
    for (int v = 0; v < 2; v++)
      for (int t = 0; t < 3; t++) begin
        m_hdr[d][v][t] = 0; m_dat[d][v][t] = 0; m_s1[d][v][t] = 0; m_s2[d][v][t] = 0;
      end
  endtask

  task automatic model_apply(input int d, input int b0, b1, b2, b3, input bit good);
    int link, vc, hi, t, hdr, dat;
    link = (d == 0) ? int'(a_link) : int'(b_link);
    if (!good) begin err_inc(d); return; end
    if (b0 == 'h00 || b0 == 'h10) begin
      if (link == 2) begin
        m_vld[d] = 1; m_seq[d] = (b2 % 16) * 256 + b3; m_ack[d] = (b0 == 0);
      end
      return;
    end
    if ((b0 / 8) % 2 == 1) return;
    vc = b0 % 8; hi = b0 / 16;
    if (vc >= 2) return;
    hdr = (b1 % 64) * 4 + b2 / 64;
    dat = (b2 % 16) * 256 + b3;
    if (hi >= 4 && hi <= 6) begin
      t = hi - 4;
      if (!m_s1[d][vc][t]) begin m_hdr[d][vc][t] = hdr; m_dat[d][vc][t] = dat; m_s1[d][vc][t] = 1; end
    end else if (hi >= 12 && hi <= 14) begin
      t = hi - 12;
      if (!m_s2[d][vc][t]) begin m_hdr[d][vc][t] = hdr; m_dat[d][vc][t] = dat; m_s2[d][vc][t] = 1; end
    end else if (hi >= 8 && hi <= 10) begin
      t = hi - 8;
      m_hdr[d][vc][t] = hdr; m_dat[d][vc][t] = dat;
    end
  endtask

  // ---------------- compare ----------------
  task automatic cmp(input int d);
    logic [15:0] e_ph, e_nph, e_cplh;
    logic [23:0] e_pd, e_npd, e_cpld;
    logic [1:0] e1, e2;
    for (int v = 0; v < 2; v++) begin
      e_ph[8*v +: 8]    = 8'(m_hdr[d][v][0]);
      e_nph[8*v +: 8]   = 8'(m_hdr[d][v][1]);
      e_cplh[8*v +: 8]  = 8'(m_hdr[d][v][2]);
      e_pd[12*v +: 12]  = 12'(m_dat[d][v][0]);
      e_npd[12*v +: 12] = 12'(m_dat[d][v][1]);
      e_cpld[12*v +: 12] = 12'(m_dat[d][v][2]);
      e1[v] = m_s1[d][v][0] && m_s1[d][v][1] && m_s1[d][v][2];
      e2[v] = m_s2[d][v][0] && m_s2[d][v][1] && m_s2[d][v][2];
    end
    if (d == 0) begin
      chk("a_fc1", a_fc1, e1); chk("a_fc2", a_fc2, e2);
      chk("a_ph", a_ph, e_ph); chk("a_nph", a_nph, e_nph); chk("a_cplh", a_cplh, e_cplh);
      chk("a_pd", a_pd, e_pd); chk("a_npd", a_npd, e_npd); chk("a_cpld", a_cpld, e_cpld);
      chk("a_err", a_err, m_err[0]); chk("a_vld", a_vld, m_vld[0]);
      if (m_vld[0]) begin chk("a_seq", a_seq, m_seq[0]); chk("a_acknack", a_ack, m_ack[0]); end
    end else begin
      chk("b_fc1", b_fc1, e1); chk("b_fc2", b_fc2, e2);
      chk("b_ph", b_ph, e_ph); chk("b_nph", b_nph, e_nph); chk("b_cplh", b_cplh, e_cplh);
      chk("b_pd", b_pd, e_pd); chk("b_npd", b_npd, e_npd); chk("b_cpld", b_cpld, e_cpld);
      chk("b_err", b_err, m_err[1]); chk("b_vld", b_vld, m_vld[1]);
      if (m_vld[1]) begin chk("b_seq", b_seq, m_seq[1]); chk("b_acknack", b_ack, m_ack[1]); end
    end
  endtask

  always @(negedge clk) begin
    cmp(0);
    cmp(1);
  end

  // ---------------- stimulus ----------------
  task automatic beat(input int d, input logic [63:0] w, input bit last, input bit frm);
    if (d == 0) begin a_tdata = w[31:0]; a_tvalid = 1; a_tlast = last; end
    else        begin b_tdata = w;       b_tvalid = 1; b_tlast = last; end
    @(negedge clk);
    chk("tready", (d == 0) ? a_tready : b_tready, 1);
    @(posedge clk); #1;
    a_tvalid = 0; a_tlast = 0; b_tvalid = 0; b_tlast = 0;
    if (frm) err_inc(d);
  endtask

  task automatic send(input int d, input logic [7:0] b0, b1, b2, b3, input bit bad);
    logic [15:0] c;
    c = dllp_crc(b0, b1, b2, b3) ^ (bad ? 16'h0001 : 16'h0000);
    if (d == 0) begin
      beat(0, {32'h0, b3, b2, b1, b0}, 0, 0);
      beat(0, {48'h0, c[7:0], c[15:8]}, 1, 0);
    end else begin
      beat(1, {16'h0, c[7:0], c[15:8], b3, b2, b1, b0}, 1, 0);
    end
    @(posedge clk); #1;
    model_apply(d, b0, b1, b2, b3, !bad);
    cap_vld = (d == 0) ? a_vld : b_vld;
    cap_seq = (d == 0) ? a_seq : b_seq;
    cap_ack = (d == 0) ? a_ack : b_ack;
    @(posedge clk); #1;
    m_vld[d] = 0;
  endtask

  task automatic send_fc(input int d, input logic [7:0] typ, input logic [7:0] h,
                         input logic [11:0] dd);
    send(d, typ, {2'b00, h[7:2]}, {h[1:0], 2'b00, dd[11:8]}, dd[7:0], 0);
  endtask

  task automatic send_seq(input int d, input logic [7:0] typ, input logic [11:0] s,
                          input bit bad);
    send(d, typ, 8'h00, {4'h0, s[11:8]}, s[7:0], bad);
  endtask

  initial begin
    model_clear(0); model_clear(1);
    m_err = '{0, 0}; m_seq = '{0, 0}; m_vld = '{0, 0}; m_ack = '{0, 0};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_a_err", a_err, 0); chk("rst_a_tready", a_tready, 0);
    chk("rst_b_vld", b_vld, 0);
    @(posedge clk); #1;

    // ---- DUT A (32-bit) ----
    a_link = DL_ACTIVE;
    send_seq(0, 8'h00, 12'h123, 0);
    chk("ack123_vld", cap_vld, 1); chk("ack123_seq", cap_seq, 'h123); chk("ack123_ack", cap_ack, 1);

    beat(0, 64'h0000_0000_1234_5678, 1, 1);          // tlast on first beat
    beat(0, 64'h0000_0000_0000_0000, 0, 0);          // 3-beat burst
    beat(0, 64'h0000_0000_0000_0000, 0, 1);
    beat(0, 64'h0000_0000_0000_0000, 1, 0);
    chk("frm_err2", a_err, 2);

    send_seq(0, 8'h10, 12'h055, 0);
    chk("after_frm_vld", cap_vld, 1); chk("after_frm_seq", cap_seq, 'h055);

    send_fc(0, 8'h95, 8'h33, 12'h044);               // VC5 >= NUM_VC
    chk("vc5_nph", a_nph, 0); chk("vc5_err", a_err, 2);
    send_fc(0, 8'h90, 8'h08, 12'h0FF);
    chk("upd_nph", a_nph[7:0], 'h08); chk("upd_npd", a_npd[11:0], 'h0FF);
    send_fc(0, 8'hE1, 8'h11, 12'h222);
    send_fc(0, 8'hC1, 8'h12, 12'h345);
    send_fc(0, 8'hD1, 8'h13, 12'h346);
    chk("fc2_vc1", a_fc2, 2'b10);
    send(0, 8'h20, 8'h00, 8'h00, 8'h00, 0);          // PM-type: ignored
    send_fc(0, 8'h48, 8'h44, 12'h444);               // type[3] set: ignored

    beat(0, 64'h0000_0000_4500_0000, 0, 0);          // first half of an Ack
    a_link = DL_INACTIVE;
    @(posedge clk); #1;
    model_clear(0);
    @(posedge clk); #1;
    chk("drop_nph", a_nph, 0); chk("drop_fc2", a_fc2, 0); chk("drop_err", a_err, 2);
    a_link = DL_ACTIVE;
    send_seq(0, 8'h00, 12'h456, 0);
    chk("relink_vld", cap_vld, 1); chk("relink_seq", cap_seq, 'h456);

    // ---- DUT B (64-bit) ----
    b_link = DL_INIT;
    send_fc(1, 8'h41, 8'h20, 12'h400);
    send_fc(1, 8'h51, 8'h20, 12'h400);
    send_fc(1, 8'h61, 8'h20, 12'h400);
    chk("b_fc1_vc1", b_fc1, 2'b10); chk("b_ph_vc1", b_ph[15:8], 'h20); chk("b_pd_vc1", b_pd[23:12], 'h400);
    send_fc(1, 8'h41, 8'h10, 12'h100);
    chk("b_first_wins", b_ph[15:8], 'h20);
    send_seq(1, 8'h00, 12'h001, 0);                  // Ack dropped in DL_INIT
    chk("init_ack_drop", cap_vld, 0);

    b_link = DL_ACTIVE;
    send_seq(1, 8'h10, 12'h7FF, 1);
    chk("bad_crc_vld", cap_vld, 0); chk("bad_crc_err", b_err, 1);
    send_seq(1, 8'h10, 12'h7FF, 0);
    chk("nak_vld", cap_vld, 1); chk("nak_ack", cap_ack, 0); chk("nak_seq", cap_seq, 'h7FF);

    beat(1, 64'h0000_0000_0000_0000, 0, 1);          // 64-bit framing error
    beat(1, 64'h0000_0000_0000_0000, 1, 0);
    send_seq(1, 8'h00, 12'h010, 1);
    send_seq(1, 8'h00, 12'h011, 1);
    chk("err_sat", b_err, 3);
    send_fc(1, 8'hA0, 8'hFF, 12'hFFF);
    send_fc(1, 8'hC0, 8'h01, 12'h002);
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
